timer: RTL

- Memory-mapped timer peripheral on the CPU request/ready bus, next to LED/UART/I2C/SD.
- Decoded in the SoC at 0x50000050–0x5000006F; the SoC passes in the offset address.
- Provides a free-running 64-bit cycle counter, a millisecond counter and a 64-bit compare with match flag and interrupt output.
- Consumes CPU requests; produces rdata/ready back into the SoC read/ready muxes.

---
 rtl/timer_pkg.sv | 25 ++
 rtl/timer_prescaler.sv | 35 +++
 rtl/timer.sv | 204 ++++++++++++++++++++
 3 files changed

// File: rtl/timer_pkg.sv
// Shared definitions for the timer peripheral: register indices (address[4:2]),
// CTRL bit positions, bus handshake state encoding and the compare reset value.
// Optional feature macro used by the design: TIMER_AUTORELOAD_EN.
package timer_pkg;

  localparam logic [2:0] REG_CYCLES_LO = 3'd0;
  localparam logic [2:0] REG_CYCLES_HI = 3'd1;
  localparam logic [2:0] REG_MS        = 3'd2;
  localparam logic [2:0] REG_CMP_LO    = 3'd3;
  localparam logic [2:0] REG_CMP_HI    = 3'd4;
  localparam logic [2:0] REG_CTRL      = 3'd5;
  localparam logic [2:0] REG_PERIOD_LO = 3'd6;

  localparam int unsigned CTRL_ENABLE = 0;
  localparam int unsigned CTRL_IRQ_EN = 1;
  localparam int unsigned CTRL_MATCH  = 2;

  typedef enum logic {
    IDLE = 1'b0,
    ACK  = 1'b1
  } bus_state_t;

  localparam logic [63:0] COMPARE_RESET = '1;

endpackage

// File: rtl/timer_prescaler.sv
// Free-running divider producing a one-cycle tick every DIVISOR enabled cycles.
// Ports:
//   i_clock    system clock
//   i_reset_n  synchronous active-low reset (count returns to 0)
//   i_enable   advance the divider this cycle; 0 freezes it
//   o_tick     high in the enabled cycle where the count is at its terminal value
module timer_prescaler #(
  parameter int unsigned DIVISOR = 50000
) (
  input  logic i_clock,
  input  logic i_reset_n,
  input  logic i_enable,
  output logic o_tick
);

  // A divisor of 0 would have no terminal count; treat it as divide-by-1.
  localparam int unsigned DIV = (DIVISOR < 1) ? 1 : DIVISOR;
  localparam int unsigned CW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [CW-1:0] TERMINAL = CW'(DIV - 1);

  logic [CW-1:0] count;
  logic          at_terminal;

  assign at_terminal = (count == TERMINAL);
  assign o_tick      = i_enable && at_terminal;

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      count <= '0;
    end else if (i_enable) begin
      count <= at_terminal ? '0 : count + 1'b1;
    end
  end

endmodule

// File: rtl/timer.sv
// Memory-mapped timer: 64-bit cycle counter, millisecond counter and 64-bit
// compare with a sticky match flag and level interrupt.
// Optional feature macro: TIMER_AUTORELOAD_EN adds PERIOD_LO (register 6);
// on a match with PERIOD_LO != 0 the compare advances by PERIOD_LO.
// Ports:
//   i_clock      system clock (FREQUENCY Hz)
//   i_reset_n    synchronous active-low reset
//   i_request    bus request, held until o_ready is seen
//   i_rw         1 = write, 0 = read
//   i_address    byte offset; bits [4:2] select the register
//   i_wdata      write data
//   o_rdata      read data, valid while o_ready = 1
//   o_ready      transfer complete
//   o_interrupt  match flag AND irq enable
module timer
  import timer_pkg::*;
#(
  parameter int unsigned FREQUENCY = 50000000
) (
  input  logic        i_clock,
  input  logic        i_reset_n,
  input  logic        i_request,
  input  logic        i_rw,
  input  logic [31:0] i_address,
  input  logic [31:0] i_wdata,
  output logic [31:0] o_rdata,
  output logic        o_ready,
  output logic        o_interrupt
);

  localparam int unsigned MS_DIVISOR = FREQUENCY / 1000;

  bus_state_t  state;
  bus_state_t  state_next;

  logic [63:0] cycles;
  logic [63:0] compare;
  logic [31:0] ms;
  logic [31:0] hi_snapshot;
  logic [31:0] read_value;
  logic        enable;
  logic        irq_en;
  logic        match;
  logic        match_hit;
  logic        ms_tick;

  logic [2:0]  reg_index;
  logic        access;
  logic        wr_access;
  logic        rd_access;
  logic        wr_ctrl;
  logic        wr_cmp_lo;
  logic        wr_cmp_hi;
  logic        unused_addr_bits;

`ifdef TIMER_AUTORELOAD_EN
  logic [31:0] period_lo;
  logic        wr_period;
`endif

  assign reg_index        = i_address[4:2];
  assign unused_addr_bits = ^{i_address[31:5], i_address[1:0]};

  // An access happens only on the IDLE->ACK transition, so a held request
  // never repeats its side effect.
  assign access    = (state == IDLE) && i_request;
  assign wr_access = access && i_rw;
  assign rd_access = access && !i_rw;
  assign wr_ctrl   = wr_access && (reg_index == REG_CTRL);
  assign wr_cmp_lo = wr_access && (reg_index == REG_CMP_LO);
  assign wr_cmp_hi = wr_access && (reg_index == REG_CMP_HI);
`ifdef TIMER_AUTORELOAD_EN
  assign wr_period = wr_access && (reg_index == REG_PERIOD_LO);
`endif

  // Compare against the pre-increment count; the flag appears one cycle later.
  assign match_hit   = (cycles == compare);
  assign o_interrupt = match && irq_en;

  // ---------------- bus handshake FSM ----------------
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (i_request) state_next = ACK;
      ACK:     if (!i_request) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    o_ready = (state == ACK);
  end

  // ---------------- counters ----------------
  timer_prescaler #(
    .DIVISOR(MS_DIVISOR)
  ) u_ms_prescaler (
    .i_clock  (i_clock),
    .i_reset_n(i_reset_n),
    .i_enable (enable),
    .o_tick   (ms_tick)
  );

  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      cycles <= '0;
      ms     <= '0;
    end else begin
      if (enable) begin
        cycles <= cycles + 64'd1;
      end
      if (ms_tick) begin
        ms <= ms + 32'd1;
      end
    end
  end

  // ---------------- control and match ----------------
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      enable <= 1'b1;
      irq_en <= 1'b0;
      match  <= 1'b0;
    end else begin
      if (wr_ctrl) begin
        enable <= i_wdata[CTRL_ENABLE];
        irq_en <= i_wdata[CTRL_IRQ_EN];
      end
      if (match_hit) begin
        match <= 1'b1;
      end else if (wr_ctrl && i_wdata[CTRL_MATCH]) begin
        match <= 1'b0;
      end
    end
  end

  // A CPU write to either compare half suppresses the reload in that cycle.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      compare <= COMPARE_RESET;
    end else if (wr_cmp_lo) begin
      compare[31:0] <= i_wdata;
    end else if (wr_cmp_hi) begin
      compare[63:32] <= i_wdata;
`ifdef TIMER_AUTORELOAD_EN
    end else if (match_hit && (period_lo != '0)) begin
      compare <= compare + {32'd0, period_lo};
`endif
    end
  end

`ifdef TIMER_AUTORELOAD_EN
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      period_lo <= '0;
    end else if (wr_period) begin
      period_lo <= i_wdata;
    end
  end
`endif

  // ---------------- read path ----------------
  always_comb begin
    read_value = '0;
    case (reg_index)
      REG_CYCLES_LO: read_value = cycles[31:0];
      REG_CYCLES_HI: read_value = hi_snapshot;
      REG_MS:        read_value = ms;
      REG_CMP_LO:    read_value = compare[31:0];
      REG_CMP_HI:    read_value = compare[63:32];
      REG_CTRL: begin
        read_value[CTRL_ENABLE] = enable;
        read_value[CTRL_IRQ_EN] = irq_en;
        read_value[CTRL_MATCH]  = match;
      end
`ifdef TIMER_AUTORELOAD_EN
      REG_PERIOD_LO: read_value = period_lo;
`endif
      default:       read_value = '0;
    endcase
  end

  // Reading CYCLES_LO freezes the upper half so a LO/HI pair is coherent.
  always_ff @(posedge i_clock) begin
    if (!i_reset_n) begin
      o_rdata     <= '0;
      hi_snapshot <= '0;
    end else if (rd_access) begin
      o_rdata <= read_value;
      if (reg_index == REG_CYCLES_LO) begin
        hi_snapshot <= cycles[63:32];
      end
    end
  end

endmodule
